// File: rtl/photon_pulse_counter_pkg.sv
// Shared definitions for the photon pulse counter.
// Holds the mode encoding, the default counter width, the default gate
// window lengths (in clk cycles at 50 MHz) and the control FSM states.
package photon_pulse_counter_pkg;

    // Default width of the window and accumulated counters
    localparam int CNT_W = 32;

    // Mode encoding as seen on oMode / iMode_Req
    localparam logic [1:0] MODE_1 = 2'd0;
    localparam logic [1:0] MODE_2 = 2'd1;
    localparam logic [1:0] MODE_3 = 2'd2;
    localparam logic [1:0] MODE_4 = 2'd3;

    // Default gate window lengths in clk cycles
    localparam int unsigned GATE_M0_DEFAULT = 32'd50_000_000;
    localparam int unsigned GATE_M1_DEFAULT = 32'd25_000_000;
    localparam int unsigned GATE_M2_DEFAULT = 32'd5_000_000;
    localparam int unsigned GATE_M3_DEFAULT = 32'd500_000;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SWITCH = 2'd2
    } pc_state_e;

endpackage

// File: rtl/photon_pulse_counter_pulse_sync_edge.sv
// Two-flop synchroniser for the asynchronous detector pulse line followed
// by a registered rising-edge detector. edge_o is high for one cycle,
// three clk edges after pulse_i is first sampled high.
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   pulse_i  raw asynchronous pulse line
//   edge_o   one-cycle rising-edge indication (registered)
module photon_pulse_counter_pulse_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic pulse_i,
    output logic edge_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic edge_q;

    // Synchroniser chain, previous-level flop and registered edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= pulse_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            edge_q  <= sync2_q & ~prev_q;
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/photon_pulse_counter.sv
// Photon pulse counter: counts synchronised rising edges of the detector
// pulse line inside a gate window whose length depends on the active mode.
// At each window close the count is published with a one-cycle strobe and
// added to a saturating accumulated total.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   en                         counting enable (low freezes the window)
//   pulse_in                   asynchronous photon pulse line
//   iMode_Req                  requested mode
//   iBlock_Mode                downstream busy, defers a mode switch
//   iClr_Acc                   clears accumulated total and saturation flag
//   oMode                      active mode
//   oData_Update               one-cycle strobe, oPulse_Counter is new
//   oPulse_Counter             count of the last closed window
//   oPulseCounter_Accumulated  saturating running total
//   oAcc_Sat                   sticky: total reached all-ones
module photon_pulse_counter
    import photon_pulse_counter_pkg::*;
#(
    parameter int unsigned GATE_M0 = GATE_M0_DEFAULT,
    parameter int unsigned GATE_M1 = GATE_M1_DEFAULT,
    parameter int unsigned GATE_M2 = GATE_M2_DEFAULT,
    parameter int unsigned GATE_M3 = GATE_M3_DEFAULT,
    parameter int          CNT_W   = photon_pulse_counter_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             pulse_in,
    input  logic [1:0]       iMode_Req,
    input  logic             iBlock_Mode,
    input  logic             iClr_Acc,
    output logic [1:0]       oMode,
    output logic             oData_Update,
    output logic [CNT_W-1:0] oPulse_Counter,
    output logic [CNT_W-1:0] oPulseCounter_Accumulated,
    output logic             oAcc_Sat
);

    // Tick counter is independent of CNT_W so narrow counters still work
    // with long gate windows.
    localparam int TICK_W = 32;
    localparam logic [TICK_W-1:0] TICK_ZERO = {TICK_W{1'b0}};
    localparam logic [TICK_W-1:0] TICK_ONE  = {{(TICK_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONES  = {CNT_W{1'b1}};

    function automatic logic [TICK_W-1:0] gate_len(input logic [1:0] mode);
        case (mode)
            MODE_1:  return TICK_W'(GATE_M0);
            MODE_2:  return TICK_W'(GATE_M1);
            MODE_3:  return TICK_W'(GATE_M2);
            MODE_4:  return TICK_W'(GATE_M3);
            default: return TICK_W'(GATE_M0);
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic             inc);
        if (inc && (cnt != CNT_ONES)) begin
            return cnt + CNT_ONE;
        end else begin
            return cnt;
        end
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[CNT_W]) begin
            return CNT_ONES;
        end else begin
            return sum[CNT_W-1:0];
        end
    endfunction

    pc_state_e         state_q, state_d;
    logic [1:0]        mode_q;
    logic [TICK_W-1:0] tick_q;
    logic [CNT_W-1:0]  win_cnt_q;
    logic [CNT_W-1:0]  pulse_cnt_q;
    logic [CNT_W-1:0]  acc_q;
    logic              upd_q;
    logic              sat_q;

    logic              edge_s;
    logic              active_s;
    logic              close_s;
    logic              switch_s;
    logic [CNT_W-1:0]  win_next_s;
    logic [CNT_W-1:0]  acc_sum_s;

    photon_pulse_counter_pulse_sync_edge u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .pulse_i (pulse_in),
        .edge_o  (edge_s)
    );

    // Window control decode and next-state logic. Counting follows en
    // directly (also in the cycle IDLE hands over to RUN), except in the
    // SWITCH cycle which restarts the window. A close always takes
    // precedence over a pending mode switch.
    always_comb begin
        active_s   = en && (state_q != ST_SWITCH);
        close_s    = active_s && (tick_q >= (gate_len(mode_q) - TICK_ONE));
        win_next_s = sat_inc(win_cnt_q, edge_s);
        acc_sum_s  = sat_add(acc_q, win_next_s);
        switch_s   = (state_q == ST_RUN) && en && !close_s &&
                     (iMode_Req != mode_q) && !iBlock_Mode;
        state_d    = state_q;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (switch_s) begin
                    state_d = ST_SWITCH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_SWITCH: state_d = ST_RUN;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Mode latch, gate tick, window count and publish strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_1;
            tick_q      <= TICK_ZERO;
            win_cnt_q   <= CNT_ZERO;
            pulse_cnt_q <= CNT_ZERO;
            upd_q       <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            if (state_q == ST_SWITCH) begin
                // Partial window and any edge in this cycle are dropped
                mode_q    <= iMode_Req;
                tick_q    <= TICK_ZERO;
                win_cnt_q <= CNT_ZERO;
            end else if (close_s) begin
                // An edge on the close cycle belongs to the closing window
                tick_q      <= TICK_ZERO;
                win_cnt_q   <= CNT_ZERO;
                pulse_cnt_q <= win_next_s;
                upd_q       <= 1'b1;
            end else if (active_s) begin
                tick_q    <= tick_q + TICK_ONE;
                win_cnt_q <= win_next_s;
            end else begin
                tick_q    <= tick_q;
                win_cnt_q <= win_cnt_q;
            end
        end
    end

    // Accumulated total and sticky saturation; a clear overrides a close
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= CNT_ZERO;
            sat_q <= 1'b0;
        end else begin
            if (iClr_Acc) begin
                acc_q <= CNT_ZERO;
                sat_q <= 1'b0;
            end else if (close_s) begin
                acc_q <= acc_sum_s;
                sat_q <= sat_q | (acc_sum_s == CNT_ONES);
            end else begin
                acc_q <= acc_q;
                sat_q <= sat_q;
            end
        end
    end

    assign oMode                     = mode_q;
    assign oData_Update              = upd_q;
    assign oPulse_Counter            = pulse_cnt_q;
    assign oPulseCounter_Accumulated = acc_q;
    assign oAcc_Sat                  = sat_q;

endmodule

// File: tb/tb_photon_pulse_counter.sv
// Scoreboard bench: a behavioural model predicts each published window
// count (queued) and the steady outputs; a monitor compares on every cycle.
// A second instance with 4-bit counters exercises the saturation paths.
module tb_photon_pulse_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        pulse_in;
    logic [1:0]  mode_req;
    logic        block;
    logic        clr;

    logic [1:0]  mode_a, mode_b;
    logic        upd_a, upd_b;
    logic [31:0] pc_a, acc_a;
    logic [3:0]  pc_b, acc_b;
    logic        sat_a, sat_b;

    int checks = 0;
    int errors = 0;

    photon_pulse_counter #(
        .GATE_M0(10), .GATE_M1(20), .GATE_M2(40), .GATE_M3(80), .CNT_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pulse_in(pulse_in),
        .iMode_Req(mode_req), .iBlock_Mode(block), .iClr_Acc(clr),
        .oMode(mode_a), .oData_Update(upd_a), .oPulse_Counter(pc_a),
        .oPulseCounter_Accumulated(acc_a), .oAcc_Sat(sat_a)
    );

    photon_pulse_counter #(
        .GATE_M0(10), .GATE_M1(20), .GATE_M2(40), .GATE_M3(80), .CNT_W(4)
    ) dut_narrow (
        .clk(clk), .rst_n(rst_n), .en(en), .pulse_in(pulse_in),
        .iMode_Req(mode_req), .iBlock_Mode(block), .iClr_Acc(clr),
        .oMode(mode_b), .oData_Update(upd_b), .oPulse_Counter(pc_b),
        .oPulseCounter_Accumulated(acc_b), .oAcc_Sat(sat_b)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    longint mx [2] = '{64'hFFFF_FFFF, 64'd15};
    bit     prev_pin;
    bit     dl [3];
    bit     armed;
    bit     in_sw;
    int     mode_m;
    int     elapsed;
    longint cnt [2];
    longint acc_m [2];
    longint last_m [2];
    bit     sat_m [2];
    bit     exp_upd;
    longint q0 [$];
    longint q1 [$];

    function automatic int gate(input int m);
        case (m)
            0: return 10;
            1: return 20;
            2: return 40;
            default: return 80;
        endcase
    endfunction

    task automatic model_reset();
        prev_pin = 1'b0;
        for (int k = 0; k < 3; k++) dl[k] = 1'b0;
        armed = 1'b0; in_sw = 1'b0; mode_m = 0; elapsed = 0; exp_upd = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cnt[i] = 0; acc_m[i] = 0; last_m[i] = 0; sat_m[i] = 1'b0;
        end
        q0.delete(); q1.delete();
    endtask

    task automatic model_step();
        bit ev;
        bit pub;
        longint tot;
        // detector rise seen at this sample reaches the window 3 samples later
        ev = dl[2]; dl[2] = dl[1]; dl[1] = dl[0];
        dl[0] = pulse_in && !prev_pin;
        prev_pin = pulse_in;
        pub = 1'b0;
        if (in_sw) begin
            mode_m = int'(mode_req); elapsed = 0; cnt[0] = 0; cnt[1] = 0;
            in_sw = 1'b0; armed = 1'b1;
        end else if (en) begin
            for (int i = 0; i < 2; i++)
                cnt[i] = (cnt[i] + longint'(ev) > mx[i]) ? mx[i] : cnt[i] + longint'(ev);
            if (elapsed == gate(mode_m) - 1) begin
                pub = 1'b1; elapsed = 0;
            end else begin
                elapsed++;
                if (armed && int'(mode_req) != mode_m && !block) in_sw = 1'b1;
            end
            armed = 1'b1;
        end else begin
            armed = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            if (pub) begin
                tot = clr ? 0 : ((acc_m[i] + cnt[i] > mx[i]) ? mx[i] : acc_m[i] + cnt[i]);
                sat_m[i] = clr ? 1'b0 : (sat_m[i] || tot == mx[i]);
                acc_m[i] = tot;
                last_m[i] = cnt[i];
                if (i == 0) q0.push_back(cnt[i]); else q1.push_back(cnt[i]);
                cnt[i] = 0;
            end else if (clr) begin
                acc_m[i] = 0; sat_m[i] = 1'b0;
            end
        end
        exp_upd = pub;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the queued window count whenever a strobe appears
    initial begin
        forever begin
            @(negedge clk);
            #1;
            chk("upd_a", longint'(upd_a), longint'(exp_upd));
            chk("upd_b", longint'(upd_b), longint'(exp_upd));
            if (upd_a) begin
                chk("queue_a_has_entry", longint'(q0.size() > 0), 1);
                if (q0.size() > 0) chk("pulse_cnt_a", longint'(pc_a), q0.pop_front());
            end
            if (upd_b) begin
                chk("queue_b_has_entry", longint'(q1.size() > 0), 1);
                if (q1.size() > 0) chk("pulse_cnt_b", longint'(pc_b), q1.pop_front());
            end
            chk("mode_a", longint'(mode_a), longint'(mode_m));
            chk("mode_b", longint'(mode_b), longint'(mode_m));
            chk("held_cnt_a", longint'(pc_a), last_m[0]);
            chk("held_cnt_b", longint'(pc_b), last_m[1]);
            chk("acc_a", longint'(acc_a), acc_m[0]);
            chk("acc_b", longint'(acc_b), acc_m[1]);
            chk("sat_a", longint'(sat_a), longint'(sat_m[0]));
            chk("sat_b", longint'(sat_b), longint'(sat_m[1]));
        end
    end

    task automatic wait_strobe(input string name, input int bound);
        bit found;
        found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            @(negedge clk);
            #2;
            if (upd_a) found = 1'b1;
        end
        chk(name, longint'(found), 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; en = 1'b0; pulse_in = 1'b0;
        mode_req = 2'd0; block = 1'b0; clr = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("reset_cnt", longint'(pc_a), 0);
        chk("reset_acc", longint'(acc_a), 0);
        @(negedge clk);
        rst_n = 1'b1; en = 1'b1;

        // three clean pulses in the first 10-cycle window
        for (int k = 0; k < 3; k++) begin
            pulse_in = 1'b1; @(negedge clk);
            pulse_in = 1'b0; @(negedge clk);
        end
        wait_strobe("t1_strobe_seen", 30);
        chk("t1_count", longint'(pc_a), 3);
        chk("t1_acc", longint'(acc_a), 3);
        wait_strobe("t1_empty_strobe_seen", 30);
        chk("t1_empty_count", longint'(pc_a), 0);
        chk("t1_empty_acc", longint'(acc_a), 3);

        // blocked mode request stays pending, then applies
        mode_req = 2'd2; block = 1'b1;
        repeat (30) @(negedge clk);
        chk("t3_mode_held", longint'(mode_a), 0);
        block = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        chk("t3_mode_applied", longint'(mode_a), 2);

        // dense pulses drive the narrow instance into saturation
        repeat (200) begin
            @(negedge clk);
            pulse_in = ~pulse_in;
        end
        #2;
        chk("t4_sat_b", longint'(sat_b), 1);
        chk("t4_acc_b_max", longint'(acc_b), 15);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #2;
        chk("t4_clr_acc_b", longint'(acc_b), 0);
        chk("t4_clr_sat_b", longint'(sat_b), 0);

        // randomized phases: pulses, enable gaps, blocking, mode, clear, reset
        for (int ph = 0; ph < 10; ph++) begin
            int pden;
            pden = int'($urandom_range(95, 5));
            for (int c = 0; c < 600; c++) begin
                @(negedge clk);
                if ($urandom_range(99, 0) < pden) pulse_in = ~pulse_in;
                if (en ? ($urandom_range(99, 0) < 2) : ($urandom_range(99, 0) < 10)) en = ~en;
                if ($urandom_range(99, 0) < 4) block = ~block;
                if ($urandom_range(149, 0) == 0) mode_req = 2'($urandom_range(3, 0));
                clr = ($urandom_range(99, 0) < 2);
                if ($urandom_range(999, 0) < 2) begin
                    rst_n = 1'b0;
                    @(negedge clk);
                    rst_n = 1'b1;
                end
            end
        end

        pulse_in = 1'b0; clr = 1'b0; en = 1'b1;
        repeat (200) @(negedge clk);
        #2;
        chk("queue_a_drained", longint'(q0.size()), 0);
        chk("queue_b_drained", longint'(q1.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
